// File: rtl/xor_fold_acc.sv
// Multi-channel XOR-fold reducer: folds each IN_W channel down to OUT_W bits and either
// passes every folded beat through or XOR-accumulates a frame into one signature.
module xor_fold_acc #(
  parameter int NCH   = 2,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*IN_W-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]     out_beats,
  output logic                 out_ovf
);

  localparam int NSLICE = IN_W / OUT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if ((IN_W % OUT_W) != 0 || IN_W < OUT_W) begin : g_bad_width
      $error("xor_fold_acc: IN_W must be an integer multiple of OUT_W");
    end
  endgenerate

  typedef enum logic {IDLE, ACC} state_t;

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [NCH*OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;
  logic [NCH*OUT_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]       out_beats_q, out_beats_d;
  logic                   out_ovf_q, out_ovf_d;

  logic [NCH*OUT_W-1:0]   fold;
  logic                   accept;
  logic                   cnt_sat;
  logic [CNT_W-1:0]       cnt_inc;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    fold = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int j = 0; j < NSLICE; j++) begin
        fold[c*OUT_W +: OUT_W] = fold[c*OUT_W +: OUT_W] ^ in_data[c*IN_W + j*OUT_W +: OUT_W];
      end
    end
  end

  // Counter holds at its maximum; hitting it again marks the frame as overflowed.
  assign cnt_sat = (cnt_q == CNT_MAX);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          mode_d = cfg_mode;
          if (!cfg_mode || in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = fold;
            out_beats_d = CNT_ONE;
            out_ovf_d   = 1'b0;
          end else begin
            acc_d   = fold;
            cnt_d   = CNT_ONE;
            ovf_d   = 1'b0;
            state_d = ACC;
          end
        end
        ACC: begin
          if (in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q ^ fold;
            out_beats_d = cnt_inc;
            out_ovf_d   = ovf_q || cnt_sat;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = IDLE;
          end else begin
            acc_d = acc_q ^ fold;
            cnt_d = cnt_inc;
            ovf_d = ovf_q || cnt_sat;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: doc/xor_fold_acc.md
Name: xor_fold_acc

Overview:
Parametrised, pipelined multi-channel XOR-fold reducer. Each beat presents NCH channels of IN_W bits. Each channel is folded to OUT_W bits by XOR-ing its OUT_W-wide slices. In PASS mode every beat yields one folded result. In ACC mode folded beats are XOR-accumulated across a frame, and a single signature is emitted on the last beat. The block sits between the datapath and the signature/compare logic, and uses valid/ready on both sides.

Parameters:
NCH, 2, number of independent channels
IN_W, 32, input width per channel; must be an integer multiple of OUT_W (elaboration error otherwise)
OUT_W, 16, folded output width per channel
CNT_W, 8, width of the per-frame beat counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
cfg_mode  input  1  0 = PASS, 1 = ACC; sampled only at frame start
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_data  input  NCH*IN_W  channel c occupies bits [c*IN_W +: IN_W]
in_last  input  1  last beat of frame; ignored in PASS
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  NCH*OUT_W  channel c occupies bits [c*OUT_W +: OUT_W]
out_beats  output  CNT_W  beats in the emitted frame; saturating
out_ovf  output  1  beat count saturated in the emitted frame

Behaviour:
- Fold rule, per channel c and bit k: fold[c][k] = XOR over j = 0..IN_W/OUT_W-1 of in[c][j*OUT_W+k]. If IN_W == OUT_W, the fold is identity.
- Handshake: in_ready = !out_valid || out_ready, identical in both modes.
  - Same-cycle consume-and-accept is supported, giving zero bubbles at full throughput.
  - While out_valid && !out_ready, out_data, out_beats and out_ovf hold stable.
  - The block never drops out_valid without a handshake.
- FSM states:
  - IDLE (frame start): on an accepted beat, latch mode_q <= cfg_mode.
    - PASS, or ACC with in_last: emit the result; stay in IDLE.
    - ACC without in_last: acc <= fold, cnt <= 1, go to ACC.
  - ACC: on each accepted beat, acc <= acc ^ fold and cnt increments.
    - On in_last: emit acc ^ fold, with out_beats = cnt+1 (saturated), then return to IDLE.
  - cfg_mode changes while in ACC are ignored until the next IDLE.
- Latency: result is registered, so out_valid rises the cycle after the accepting edge (1 cycle).
- PASS output: out_data = fold of that beat, out_beats = 1, out_ovf = 0.
- Counter: saturates at 2^CNT_W-1 and sets a sticky ovf flag for the frame. out_ovf reports that flag. The flag and cnt clear when the frame is emitted.
- Single-beat ACC frame (in_last on the first beat): out_data = fold, out_beats = 1.
- Reset: rst_n low on a clock edge clears the following, with no output emitted for an in-progress frame:
  - out_valid = 0, out_data = 0, out_beats = 0, out_ovf = 0
  - acc = 0, cnt = 0, mode_q = 0
  - FSM returns to IDLE
  - in_ready is 1 after reset.
- Channels are fully independent bitwise. There is no cross-channel mixing.

Test Plan:
- PASS, defaults, ch0 = 0x12345678, ch1 = 0xFFFF0000, out_ready = 1 -> one cycle later out_data ch0 = 0x444C, ch1 = 0xFFFF, out_beats = 1.
- ACC frame ch0 beats 0x0001FFFF, 0x00010001, 0xAAAA0000 (last) -> single output ch0 = 0x5554, out_beats = 3, out_ovf = 0; no out_valid before the last beat.
- Backpressure: hold out_ready = 0 for 5 cycles with out_valid high -> in_ready = 0, out_data stable; then back-to-back PASS beats with out_ready = 1 -> one result per cycle, no gaps.
- Saturation with CNT_W = 2: ACC frame of 6 beats -> out_beats = 3, out_ovf = 1; the next frame reports out_ovf = 0.
- Mode toggle mid-frame: start an ACC frame, set cfg_mode = 0 after beat 1, end with in_last on beat 3 -> one accumulated output; the following beat is treated as PASS.
- Reset mid-frame: assert rst_n = 0 after 2 ACC beats, release, send a single-beat ACC frame 0x00000003 -> out_data ch0 = 0x0003, out_beats = 1, with no stale accumulation.
